// File: rtl/latch_response_checker.sv
// latch_response_checker
//
// Receive-end monitor for the storage-element labs. It watches the stimulus
// driven into a D latch (MODE 0), SR flip-flop (MODE 1) or T flip-flop
// (MODE 2, T on input D). It runs its own reference model and compares the
// DUT's Q/Qn against that model SETTLE clk cycles later. It counts samples,
// errors and illegal SR edges, and it records the cycle of the first error.
//
// Parameters:
//   MODE   element under check (0 = D latch, 1 = SR FF, 2 = T FF)
//   SETTLE clk cycles between sampling the inputs and comparing Q (1..8)
//   CNT_W  width of every counter; all counters saturate at all-ones
//
// Ports:
//   clk           in   sampling clock, rising edge
//   rst           in   asynchronous active-high reset
//   en            in   1 arms/runs the checker, 0 returns it to IDLE
//   C, D, S, R    in   DUT enable/clock, data/T, set, reset as driven
//   Q, Qn         in   DUT true/complement outputs
//   mismatch      out  one-cycle pulse on a failing compare
//   sample_cnt    out  compares performed
//   err_cnt       out  failing compares
//   illegal_cnt   out  SR rising edges with S=R=1
//   first_err_cyc out  cycle count (since SYNC) of the first failure
//   pass          out  RUN/HALT with at least one sample and no errors
//   state         out  IDLE=0, SYNC=1, RUN=2, HALT=3
//
// Optional feature macro: STOP_ON_ERR_EN. When it is defined, the first
// failing compare sends RUN to HALT, and all checking state freezes there.
module latch_response_checker #(
  parameter int MODE   = 0,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             C,
  input  logic             D,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Qn,
  output logic             mismatch,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic             pass,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic              model_q, model_d;
  logic              known_q, known_d;
  logic              c_prev_q, c_prev_d;
  logic [SETTLE-1:0] vld_q, vld_d;
  logic [SETTLE-1:0] kn_q, kn_d;
  logic [SETTLE-1:0] md_q, md_d;
  logic [CNT_W-1:0]  sample_q, sample_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  ill_q, ill_d;
  logic [CNT_W-1:0]  fec_q, fec_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              mismatch_q, mismatch_d;
  logic              rise;
  logic              fail;

  always_comb begin
    state_d    = state_q;
    model_d    = model_q;
    known_d    = known_q;
    c_prev_d   = c_prev_q;
    vld_d      = vld_q;
    kn_d       = kn_q;
    md_d       = md_q;
    sample_d   = sample_q;
    err_d      = err_q;
    ill_d      = ill_q;
    fec_d      = fec_q;
    cyc_d      = cyc_q;
    mismatch_d = 1'b0;
    fail       = 1'b0;
    rise       = C & ~c_prev_q;

    // Dropping en wins over everything, including a compare due this cycle.
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          sample_d = '0;
          err_d    = '0;
          ill_d    = '0;
          fec_d    = '0;
          cyc_d    = '0;
          model_d  = Q;
          known_d  = 1'b1;
          c_prev_d = C;
          vld_d    = '0;
          state_d  = RUN;
        end
        RUN: begin
          c_prev_d = C;
          cyc_d    = sat_inc(cyc_q);

          // Reference model update
          if (MODE == 0) begin
            if (C) begin
              model_d = D;
              known_d = 1'b1;
            end
          end else if (MODE == 1) begin
            if (rise) begin
              case ({S, R})
                2'b10: begin model_d = 1'b1; known_d = 1'b1; end
                2'b01: begin model_d = 1'b0; known_d = 1'b1; end
                2'b11: begin known_d = 1'b0; ill_d = sat_inc(ill_q); end
                default: ;
              endcase
            end
          end else begin
            if (rise && D) model_d = ~model_q;
          end

          // Delay line: the head takes this cycle's expectation
          for (int i = SETTLE - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
            kn_d[i]  = kn_q[i-1];
            md_d[i]  = md_q[i-1];
          end
          vld_d[0] = 1'b1;
          kn_d[0]  = known_d;
          md_d[0]  = model_d;

          // Tail compare. An unknown expectation still checks Qn against Q.
          if (vld_q[SETTLE-1]) begin
            if (kn_q[SETTLE-1]) begin
              sample_d = sat_inc(sample_q);
              fail     = (Q != md_q[SETTLE-1]) || (Qn == Q);
            end else if (Qn == Q) begin
              sample_d = sat_inc(sample_q);
              fail     = 1'b1;
            end
          end

          if (fail) begin
            mismatch_d = 1'b1;
            err_d      = sat_inc(err_q);
            if (err_q == '0) fec_d = cyc_q;
`ifdef STOP_ON_ERR_EN
            state_d = HALT;
`endif
          end
        end
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Register stage: FSM, model, delay line and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      model_q    <= 1'b0;
      known_q    <= 1'b0;
      c_prev_q   <= 1'b0;
      vld_q      <= '0;
      kn_q       <= '0;
      md_q       <= '0;
      sample_q   <= '0;
      err_q      <= '0;
      ill_q      <= '0;
      fec_q      <= '0;
      cyc_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      model_q    <= model_d;
      known_q    <= known_d;
      c_prev_q   <= c_prev_d;
      vld_q      <= vld_d;
      kn_q       <= kn_d;
      md_q       <= md_d;
      sample_q   <= sample_d;
      err_q      <= err_d;
      ill_q      <= ill_d;
      fec_q      <= fec_d;
      cyc_q      <= cyc_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch      = mismatch_q;
  assign sample_cnt    = sample_q;
  assign err_cnt       = err_q;
  assign illegal_cnt   = ill_q;
  assign first_err_cyc = fec_q;
  assign state         = state_q;
  assign pass          = ((state_q == RUN) || (state_q == HALT)) &&
                         (sample_q != '0) && (err_q == '0);

endmodule

// File: tb/tb_latch_response_checker.sv
// Directed testbench for latch_response_checker. It uses three instances:
// MODE 0 (D latch), MODE 1 (SR FF) and MODE 2 (T FF, 4-bit counters so that
// saturation is reachable). All three use SETTLE=2. The DUT responses the
// bench drives are delayed by SETTLE cycles, as the lab loop would return them.
module tb_latch_response_checker;
  localparam int SET = 2;
`ifdef STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic C = 1'b0, D = 1'b0, S = 1'b0, R = 1'b0;
  logic q0 = 1'b0, qn0 = 1'b1, q1 = 1'b0, qn1 = 1'b1, q2 = 1'b0, qn2 = 1'b1;

  logic        mm0, mm1, mm2, ps0, ps1, ps2;
  logic [1:0]  st0, st1, st2;
  logic [15:0] sc0, ec0, ic0, fe0, sc1, ec1, ic1, fe1;
  logic [3:0]  sc2, ec2, ic2, fe2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  latch_response_checker #(.MODE(0), .SETTLE(SET), .CNT_W(16)) u_m0 (
    .clk(clk), .rst(rst), .en(en), .C(C), .D(D), .S(S), .R(R), .Q(q0), .Qn(qn0),
    .mismatch(mm0), .sample_cnt(sc0), .err_cnt(ec0), .illegal_cnt(ic0),
    .first_err_cyc(fe0), .pass(ps0), .state(st0));

  latch_response_checker #(.MODE(1), .SETTLE(SET), .CNT_W(16)) u_m1 (
    .clk(clk), .rst(rst), .en(en), .C(C), .D(D), .S(S), .R(R), .Q(q1), .Qn(qn1),
    .mismatch(mm1), .sample_cnt(sc1), .err_cnt(ec1), .illegal_cnt(ic1),
    .first_err_cyc(fe1), .pass(ps1), .state(st1));

  latch_response_checker #(.MODE(2), .SETTLE(SET), .CNT_W(4)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .C(C), .D(D), .S(S), .R(R), .Q(q2), .Qn(qn2),
    .mismatch(mm2), .sample_cnt(sc2), .err_cnt(ec2), .illegal_cnt(ic2),
    .first_err_cyc(fe2), .pass(ps2), .state(st2));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // IDLE -> SYNC -> RUN; the next rising edge is RUN cycle 0.
  task automatic start_run();
    en = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if ({mm0, ps0, st0, sc0, ec0, ic0, fe0} !== '0) begin n_fail++; $display("FAIL reset_m0 got %h want 0", {mm0, ps0, st0, sc0, ec0, ic0, fe0}); end
    n_tests++; if ({mm1, ps1, st1, sc1, ec1, ic1, fe1} !== '0) begin n_fail++; $display("FAIL reset_m1 got %h want 0", {mm1, ps1, st1, sc1, ec1, ic1, fe1}); end
    n_tests++; if ({mm2, ps2, st2, sc2, ec2, ic2, fe2} !== '0) begin n_fail++; $display("FAIL reset_m2 got %h want 0", {mm2, ps2, st2, sc2, ec2, ic2, fe2}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_tests++; if (st0 !== 2'd0) begin n_fail++; $display("FAIL idle_no_en got %0d want 0", st0); end
  endtask

  task automatic test_d_latch();
    logic lat;
    logic hist [200];
    bit   saw_mm;
    q0 = 1'b0; qn0 = 1'b1; C = 1'b0; D = 1'b0; lat = 1'b0; saw_mm = 1'b0;
    start_run();
    n_tests++; if (st0 !== 2'd2) begin n_fail++; $display("FAIL t1_run_state got %0d want 2", st0); end
    for (int n = 0; n < 200; n++) begin
      C = ((n / 10) % 2) == 1;
      D = 1'($urandom_range(0, 1));
      if (C) lat = D;
      hist[n] = lat;
      q0  = (n >= SET) ? hist[n-SET] : 1'b0;
      qn0 = ~q0;
      tick();
      if (mm0) saw_mm = 1'b1;
    end
    n_tests++; if (saw_mm !== 1'b0) begin n_fail++; $display("FAIL t1_no_pulse got %0d want 0", saw_mm); end
    n_tests++; if (sc0 !== 16'd198) begin n_fail++; $display("FAIL t1_samples got %0d want 198", sc0); end
    n_tests++; if (ec0 !== 16'd0) begin n_fail++; $display("FAIL t1_errors got %0d want 0", ec0); end
    n_tests++; if (ps0 !== 1'b1) begin n_fail++; $display("FAIL t1_pass got %0d want 1", ps0); end
    en = 1'b0;
    tick();
    n_tests++; if (st0 !== 2'd0) begin n_fail++; $display("FAIL t1_idle got %0d want 0", st0); end
    n_tests++; if (sc0 !== 16'd198) begin n_fail++; $display("FAIL t1_hold got %0d want 198", sc0); end
    n_tests++; if (ps0 !== 1'b0) begin n_fail++; $display("FAIL t1_pass_idle got %0d want 0", ps0); end
  endtask

  task automatic test_d_forced_low();
    logic exp_mm;
    logic [15:0] exp_err;
    q0 = 1'b0; qn0 = 1'b1; C = 1'b1; D = 1'b0;
    start_run();
    for (int n = 0; n < 26; n++) begin
      D = (n >= 20);
      q0 = 1'b0; qn0 = 1'b1;
      tick();
      exp_mm = STOP ? (n == 22) : (n >= 22);
      n_tests++; if (mm0 !== exp_mm) begin n_fail++; $display("FAIL t2_pulse_c%0d got %0d want %0d", n, mm0, exp_mm); end
    end
    exp_err = STOP ? 16'd1 : 16'd4;
    n_tests++; if (fe0 !== 16'd22) begin n_fail++; $display("FAIL t2_first_err got %0d want 22", fe0); end
    n_tests++; if (ec0 !== exp_err) begin n_fail++; $display("FAIL t2_errors got %0d want %0d", ec0, exp_err); end
    n_tests++; if (sc0 !== (STOP ? 16'd21 : 16'd24)) begin n_fail++; $display("FAIL t2_samples got %0d want %0d", sc0, STOP ? 21 : 24); end
    // en falls on a cycle whose compare would fail: no pulse, no count
    en = 1'b0;
    tick();
    n_tests++; if (mm0 !== 1'b0) begin n_fail++; $display("FAIL t2_abort_pulse got %0d want 0", mm0); end
    n_tests++; if (ec0 !== exp_err) begin n_fail++; $display("FAIL t2_abort_cnt got %0d want %0d", ec0, exp_err); end
    n_tests++; if (st0 !== 2'd0) begin n_fail++; $display("FAIL t2_abort_state got %0d want 0", st0); end
  endtask

  task automatic test_sr_illegal();
    logic [9:0] cv, sv, rv, qv;
    cv = 10'b0010101010;
    sv = 10'b0000001010;
    rv = 10'b0010001000;
    qv = 10'b0111111000;
    C = 1'b0; S = 1'b0; R = 1'b0; q1 = 1'b0; qn1 = 1'b1;
    start_run();
    for (int n = 0; n < 10; n++) begin
      C = cv[n]; S = sv[n]; R = rv[n];
      q1 = qv[n]; qn1 = ~qv[n];
      tick();
      if (n == 3) begin
        n_tests++; if (ic1 !== 16'd1) begin n_fail++; $display("FAIL t3_illegal got %0d want 1", ic1); end
      end
      if (n == 8) begin
        n_tests++; if (sc1 !== 16'd3) begin n_fail++; $display("FAIL t3_unknown_skip got %0d want 3", sc1); end
      end
    end
    n_tests++; if (sc1 !== 16'd4) begin n_fail++; $display("FAIL t3_rearm got %0d want 4", sc1); end
    n_tests++; if (ec1 !== 16'd0) begin n_fail++; $display("FAIL t3_errors got %0d want 0", ec1); end
    n_tests++; if (ic1 !== 16'd1) begin n_fail++; $display("FAIL t3_illegal_end got %0d want 1", ic1); end
    n_tests++; if (ps1 !== 1'b1) begin n_fail++; $display("FAIL t3_pass got %0d want 1", ps1); end
    en = 1'b0; S = 1'b0; R = 1'b0;
    tick();
  endtask

  task automatic test_t_toggle();
    logic tq, cp;
    logic hist [10];
    bit   saw_mm;
    C = 1'b0; D = 1'b1; q2 = 1'b0; qn2 = 1'b1; tq = 1'b0; cp = 1'b0; saw_mm = 1'b0;
    start_run();
    for (int n = 0; n < 10; n++) begin
      C = (n % 2) == 1;
      if (C && !cp && D) tq = ~tq;
      cp = C;
      hist[n] = tq;
      q2  = (n >= SET) ? hist[n-SET] : 1'b0;
      qn2 = ~q2;
      tick();
      if (mm2) saw_mm = 1'b1;
    end
    n_tests++; if (saw_mm !== 1'b0) begin n_fail++; $display("FAIL t4_no_pulse got %0d want 0", saw_mm); end
    n_tests++; if (sc2 !== 4'd8) begin n_fail++; $display("FAIL t4_samples got %0d want 8", sc2); end
    n_tests++; if (ec2 !== 4'd0) begin n_fail++; $display("FAIL t4_errors got %0d want 0", ec2); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_qn_tied();
    C = 1'b0; D = 1'b0; q2 = 1'b0; qn2 = 1'b0;
    start_run();
    tick(); tick();
    n_tests++; if (mm2 !== 1'b0) begin n_fail++; $display("FAIL t5_early_pulse got %0d want 0", mm2); end
    tick();
    n_tests++; if (mm2 !== 1'b1) begin n_fail++; $display("FAIL t5_first_pulse got %0d want 1", mm2); end
    n_tests++; if (ec2 !== 4'd1) begin n_fail++; $display("FAIL t5_errors got %0d want 1", ec2); end
    n_tests++; if (fe2 !== 4'd2) begin n_fail++; $display("FAIL t5_first_err got %0d want 2", fe2); end
    for (int n = 3; n < 30; n++) tick();
    if (STOP) begin
      n_tests++; if (st2 !== 2'd3) begin n_fail++; $display("FAIL t5_halt got %0d want 3", st2); end
      n_tests++; if (ec2 !== 4'd1) begin n_fail++; $display("FAIL t5_frozen got %0d want 1", ec2); end
    end else begin
      n_tests++; if (ec2 !== 4'd15) begin n_fail++; $display("FAIL t5_err_sat got %0d want 15", ec2); end
      n_tests++; if (sc2 !== 4'd15) begin n_fail++; $display("FAIL t5_smp_sat got %0d want 15", sc2); end
      n_tests++; if (mm2 !== 1'b1) begin n_fail++; $display("FAIL t5_sat_pulse got %0d want 1", mm2); end
    end
    n_tests++; if (fe2 !== 4'd2) begin n_fail++; $display("FAIL t5_first_hold got %0d want 2", fe2); end
    en = 1'b0; qn2 = 1'b1;
    tick();
  endtask

  task automatic test_stop_on_err();
    q0 = 1'b0; qn0 = 1'b1; C = 1'b1; D = 1'b0;
    start_run();
    for (int n = 0; n < 53; n++) begin
      D = (n >= 48);
      tick();
      if (n == 50) begin
        n_tests++; if (mm0 !== 1'b1) begin n_fail++; $display("FAIL t6_pulse got %0d want 1", mm0); end
        n_tests++; if (st0 !== (STOP ? 2'd3 : 2'd2)) begin n_fail++; $display("FAIL t6_state51 got %0d want %0d", st0, STOP ? 3 : 2); end
      end
    end
    n_tests++; if (ec0 !== (STOP ? 16'd1 : 16'd3)) begin n_fail++; $display("FAIL t6_errors got %0d want %0d", ec0, STOP ? 1 : 3); end
    n_tests++; if (mm0 !== !STOP) begin n_fail++; $display("FAIL t6_halt_pulse got %0d want %0d", mm0, !STOP); end
    n_tests++; if (st0 !== (STOP ? 2'd3 : 2'd2)) begin n_fail++; $display("FAIL t6_state got %0d want %0d", st0, STOP ? 3 : 2); end
    en = 1'b0; D = 1'b0;
    tick();
    start_run();
    n_tests++; if ({sc0, ec0, fe0} !== '0) begin n_fail++; $display("FAIL t6_resync got %h want 0", {sc0, ec0, fe0}); end
    n_tests++; if (st0 !== 2'd2) begin n_fail++; $display("FAIL t6_resync_state got %0d want 2", st0); end
  endtask

  task automatic test_async_reset();
    // Continues in RUN from the previous task (model 0); Q stuck at 0 while D=1
    C = 1'b1; D = 1'b1; q0 = 1'b0; qn0 = 1'b1;
    for (int n = 0; n < 7; n++) tick();
    n_tests++; if (ec0 !== (STOP ? 16'd1 : 16'd5)) begin n_fail++; $display("FAIL t7_pre_errors got %0d want %0d", ec0, STOP ? 1 : 5); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({mm0, ps0, st0, sc0, ec0, ic0, fe0} !== '0) begin n_fail++; $display("FAIL t7_async got %h want 0", {mm0, ps0, st0, sc0, ec0, ic0, fe0}); end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    tick();
    n_tests++; if (st0 !== 2'd0) begin n_fail++; $display("FAIL t7_after got %0d want 0", st0); end
  endtask

  initial begin
    test_reset();
    test_d_latch();
    test_d_forced_low();
    test_sr_illegal();
    test_t_toggle();
    test_qn_tied();
    test_stop_on_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/latch_response_checker.md
Name: latch_response_checker

Overview:
- Self-checking response monitor for the storage-element labs: the receive end of the stimulus/DUT loop.
- Samples the control and data inputs driven into a D latch, SR flip-flop or T flip-flop, runs its own golden model and compares the DUT's Q/Qn after a settle delay.
- Counts samples, mismatches and illegal SR inputs, and records the cycle of the first error, so a lab run ends with a single pass/fail verdict.

Parameters:
- MODE, 0, element under check: 0 = D latch, 1 = SR flip-flop (rising edge of C), 2 = T flip-flop (rising edge of C, T taken from D input).
- SETTLE, 2, clk cycles between sampling the inputs and comparing Q; legal range 1..8.
- CNT_W, 16, width of every counter; counters saturate at all-ones.

Ports:
- clk  input  1  sampling clock, rising-edge active.
- rst  input  1  asynchronous active-high reset.
- en  input  1  level; 1 arms/runs the checker, 0 returns it to IDLE.
- C  input  1  DUT enable/clock, as driven to the DUT.
- D  input  1  DUT data (MODE 0) or T (MODE 2).
- S  input  1  DUT set (MODE 1).
- R  input  1  DUT reset (MODE 1).
- Q  input  1  DUT output.
- Qn  input  1  DUT complement output.
- mismatch  output  1  one-cycle pulse on any failing compare.
- sample_cnt  output  CNT_W  compares performed.
- err_cnt  output  CNT_W  failing compares.
- illegal_cnt  output  CNT_W  SR edges with S=R=1.
- first_err_cyc  output  CNT_W  cycle count since SYNC of the first mismatch.
- pass  output  1  1 when in RUN/HALT, sample_cnt != 0 and err_cnt == 0.
- state  output  2  FSM state: IDLE=0, SYNC=1, RUN=2, HALT=3.

Behaviour:
Reset:
- All outputs and counters 0; state = IDLE.
- Model register 0 and marked unknown; delay line cleared to invalid.

FSM:
- IDLE -> SYNC when en=1.
- SYNC (exactly 1 cycle):
  - clear all counters and the cycle counter;
  - model := sampled Q, known := 1;
  - c_d := C;
  - go to RUN.
- RUN -> HALT only under STOP_ON_ERR_EN.
- Any state -> IDLE when en=0. Counters hold their values in IDLE until the next SYNC.

Model update, each RUN cycle, using inputs registered once (c_d = previous C):
- MODE 0: if C=1, model := D and known := 1; else hold.
- MODE 1, on rising edge (C & ~c_d):
  - S=1,R=0: model := 1, known := 1.
  - S=0,R=1: model := 0, known := 1.
  - S=0,R=0: hold.
  - S=1,R=1: illegal_cnt++ and known := 0; stays unknown until the next legal set/reset edge.
- MODE 2, on rising edge: if D=1, model := ~model; else hold.

Comparison:
- {known, model} enters a SETTLE-deep shift register.
- Compare at the tail only if the tail entry is valid and known:
  - sample_cnt++;
  - fail if Q != expected, or if Qn != ~Q.
- A Qn != ~Q failure is also checked while the model is unknown; it counts as a sample and an error.
- Valid entries exist only for cycles sampled in RUN, so the first compare occurs SETTLE cycles after SYNC.

On fail:
- mismatch = 1 for that cycle; err_cnt++.
- If err_cnt was 0, first_err_cyc := current cycle count.

Saturation: counters stop at 2^CNT_W-1; the cycle counter saturates too.

Simultaneous events: en falling on a compare cycle aborts that compare (no count, no pulse).

Async reset mid-run: immediate return to the reset state; no partial counts are retained.

Optional Feature:
STOP_ON_ERR_EN
- Defined: the first failing compare moves RUN -> HALT on the next edge. In HALT, counters, first_err_cyc and the delay line freeze; mismatch stays 0; only en=0 or rst leaves HALT.
- Undefined: HALT is unreachable; checking continues and counters saturate.

Test Plan:
- MODE 0, SETTLE=2, DUT is a correct D latch; C toggles every 10 clk, D random for 200 cycles -> err_cnt=0, sample_cnt=198, pass=1, no mismatch pulse.
- MODE 0, Q forced to 0 with C=1, D=1 held from cycle 20 -> mismatch first pulses at cycle 22; first_err_cyc=22; err_cnt increments every cycle after that.
- MODE 1, edge with S=1,R=1 then edges with S=0,R=0 -> illegal_cnt=1; those cycles are not counted by sample_cnt; next edge with S=0,R=1 and DUT Q=0 re-arms; err_cnt=0.
- MODE 2, Qn tied equal to Q -> mismatch on first compare (cycle SETTLE after SYNC); err_cnt=1 after that compare.
- STOP_ON_ERR_EN defined, error injected at cycle 50 -> state=3 from cycle 51; err_cnt=1 frozen; en=0 then en=1 -> SYNC clears counters to 0.
- rst asserted mid-RUN with err_cnt=5 -> all outputs 0 and state=0 immediately, without waiting for a clk edge.
